multicycle_addsub: RTL and testbench

MULTICYCLE_ADDSUB -- requirements
Module: multicycle_addsub

---
 rtl/multicycle_addsub.sv | 99 +++++++++
 tb/tb_multicycle_addsub.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_addsub.sv
// Chunked multicycle adder/subtractor: one CHUNK-bit slice per cycle, LSB slice first.
// Results are committed to sum/cout/ovf only when the final slice completes.
module multicycle_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             done_o
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d;
  logic             carry_q;
  logic [IdxW-1:0]  idx_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q, done_q;

  logic [CHUNK-1:0] slice_a, slice_b, slice_s;
  logic             slice_c;
  logic             msb_ovf;

  always_comb begin
    slice_a = a_q[int'(idx_q) * CHUNK +: CHUNK];
    slice_b = b_q[int'(idx_q) * CHUNK +: CHUNK];
    {slice_c, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry_q};
    acc_d = acc_q;
    acc_d[int'(idx_q) * CHUNK +: CHUNK] = slice_s;
    // Carry into the MSB is recovered from its sum bit; XOR with carry out gives overflow.
    msb_ovf = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ acc_d[WIDTH-1] ^ slice_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            // Subtract is folded into the operands: B is inverted and the +1 rides on carry.
            a_q     <= a_i;
            b_q     <= sub_i ? ~b_i : b_i;
            carry_q <= sub_i | cin_i;
            idx_q   <= '0;
            acc_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          acc_q   <= acc_d;
          carry_q <= slice_c;
          if (idx_q == LastIdx) begin
            sum_q   <= acc_d;
            cout_q  <= slice_c;
            ovf_q   <= msb_ovf;
            done_q  <= 1'b1;
            idx_q   <= '0;
            state_q <= StIdle;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready_o = (state_q == StIdle);
  assign sum_o   = sum_q;
  assign cout_o  = cout_q;
  assign ovf_o   = ovf_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_multicycle_addsub.sv
// Directed and randomized checks of multicycle_addsub at CHUNK = 1, 4 and 16 (WIDTH = 16).
module tb_multicycle_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start_v;
  logic [2:0]  ready_v, cout_v, ovf_v, done_v;
  logic [15:0] sum_v [3];
  logic [15:0] a, b;
  logic        cin, sub;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned Ch = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
    multicycle_addsub #(.WIDTH(16), .CHUNK(Ch)) u_dut (
      .clk    (clk),
      .rst    (rst),
      .start_i(start_v[g]),
      .ready_o(ready_v[g]),
      .a_i    (a),
      .b_i    (b),
      .cin_i  (cin),
      .sub_i  (sub),
      .sum_o  (sum_v[g]),
      .cout_o (cout_v[g]),
      .ovf_o  (ovf_v[g]),
      .done_o (done_v[g])
    );
  end

  function automatic int chunk_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 4 : 16);
  endfunction

  // Issue one operation on instance k and return the edge count from acceptance to done.
  task automatic run_op(input int k, input logic [15:0] ai, input logic [15:0] bi,
                        input logic ci, input logic si, output int lat);
    int guard = 0;
    while (!ready_v[k] && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    a = ai; b = bi; cin = ci; sub = si;
    start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    lat = 0;
    while (!done_v[k] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_v = '0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready_v[1] !== 1'b1) begin
      errs++; $display("FAIL reset_ready: got %b want 1", ready_v[1]);
    end
    checks++;
    if (sum_v[1] !== 16'h0000) begin
      errs++; $display("FAIL reset_sum: got %h want 0000", sum_v[1]);
    end
    checks++;
    if ({cout_v[1], ovf_v[1], done_v[1]} !== 3'b000) begin
      errs++; $display("FAIL reset_flags: got cout/ovf/done=%b want 000",
                       {cout_v[1], ovf_v[1], done_v[1]});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_wrap();
    int lat;
    run_op(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    checks++;
    if (lat != 4) begin
      errs++; $display("FAIL wrap_latency: got %0d want 4", lat);
    end
    checks++;
    if ({sum_v[1], cout_v[1], ovf_v[1]} !== {16'h0000, 1'b1, 1'b0}) begin
      errs++; $display("FAIL wrap_result: got sum=%h cout=%b ovf=%b want 0000 1 0",
                       sum_v[1], cout_v[1], ovf_v[1]);
    end
    @(posedge clk); #1;
    checks++;
    if (done_v[1] !== 1'b0) begin
      errs++; $display("FAIL done_pulse_width: got %b want 0", done_v[1]);
    end
    checks++;
    if ({sum_v[1], cout_v[1]} !== {16'h0000, 1'b1}) begin
      errs++; $display("FAIL result_hold: got sum=%h cout=%b want 0000 1", sum_v[1], cout_v[1]);
    end
  endtask

  task automatic test_ovf_sub();
    int lat;
    run_op(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
    checks++;
    if ({sum_v[1], cout_v[1], ovf_v[1]} !== {16'h8000, 1'b0, 1'b1}) begin
      errs++; $display("FAIL add_ovf: got sum=%h cout=%b ovf=%b want 8000 0 1",
                       sum_v[1], cout_v[1], ovf_v[1]);
    end
    run_op(1, 16'h0005, 16'h0007, 1'b1, 1'b1, lat);
    checks++;
    if ({sum_v[1], cout_v[1], ovf_v[1]} !== {16'hFFFE, 1'b0, 1'b0}) begin
      errs++; $display("FAIL sub_borrow: got sum=%h cout=%b ovf=%b want fffe 0 0",
                       sum_v[1], cout_v[1], ovf_v[1]);
    end
    run_op(1, 16'h1234, 16'h4321, 1'b1, 1'b0, lat);
    checks++;
    if ({sum_v[1], cout_v[1], ovf_v[1]} !== {16'h5556, 1'b0, 1'b0}) begin
      errs++; $display("FAIL add_cin: got sum=%h cout=%b ovf=%b want 5556 0 0",
                       sum_v[1], cout_v[1], ovf_v[1]);
    end
    run_op(1, 16'h8000, 16'h0001, 1'b0, 1'b1, lat);
    checks++;
    if ({sum_v[1], cout_v[1], ovf_v[1]} !== {16'h7FFF, 1'b1, 1'b1}) begin
      errs++; $display("FAIL sub_ovf: got sum=%h cout=%b ovf=%b want 7fff 1 1",
                       sum_v[1], cout_v[1], ovf_v[1]);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic saw_ready;
    a = 16'h0100; b = 16'h0011; cin = 1'b0; sub = 1'b0;
    start_v[1] = 1'b1;
    @(posedge clk); #1;
    // Hold start and scramble operands while the first op is running.
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1;
    saw_ready = 1'b0;
    lat = 0;
    while (!done_v[1] && lat < 40) begin
      if (ready_v[1]) saw_ready = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (saw_ready !== 1'b0) begin
      errs++; $display("FAIL run_ready: got ready=1 during run want 0");
    end
    checks++;
    if (lat != 4 || sum_v[1] !== 16'h0111 || cout_v[1] !== 1'b0) begin
      errs++; $display("FAIL ignore_start: got lat=%0d sum=%h cout=%b want 4 0111 0",
                       lat, sum_v[1], cout_v[1]);
    end
    @(posedge clk); #1;
    start_v[1] = 1'b0;
    checks++;
    if (ready_v[1] !== 1'b0) begin
      errs++; $display("FAIL b2b_accept: got ready=%b want 0", ready_v[1]);
    end
    lat = 0;
    while (!done_v[1] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 4 || {sum_v[1], cout_v[1], ovf_v[1]} !== {16'h0000, 1'b1, 1'b0}) begin
      errs++; $display("FAIL b2b_result: got lat=%0d sum=%h cout=%b ovf=%b want 4 0000 1 0",
                       lat, sum_v[1], cout_v[1], ovf_v[1]);
    end
  endtask

  task automatic test_abort();
    int lat;
    logic saw_done;
    run_op(1, 16'h00F0, 16'h000F, 1'b0, 1'b0, lat);
    checks++;
    if (sum_v[1] !== 16'h00FF) begin
      errs++; $display("FAIL pre_abort_sum: got %h want 00ff", sum_v[1]);
    end
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
    start_v[1] = 1'b1;
    @(posedge clk); #1;
    start_v[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (ready_v[1] !== 1'b1 || sum_v[1] !== 16'h0000 || {cout_v[1], ovf_v[1]} !== 2'b00) begin
      errs++; $display("FAIL abort_clear: got ready=%b sum=%h cout=%b ovf=%b want 1 0000 0 0",
                       ready_v[1], sum_v[1], cout_v[1], ovf_v[1]);
    end
    saw_done = 1'b0;
    repeat (8) begin
      if (done_v[1]) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (saw_done !== 1'b0 || sum_v[1] !== 16'h0000) begin
      errs++; $display("FAIL abort_no_done: got done_seen=%b sum=%h want 0 0000",
                       saw_done, sum_v[1]);
    end
  endtask

  task automatic test_sweep();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 1000; i++) begin
        logic [15:0] ra, rb, bb;
        logic        rc, rs, eovf;
        logic [16:0] full;
        int          lat;
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom);
        rs = 1'($urandom);
        bb = rs ? ~rb : rb;
        full = {1'b0, ra} + {1'b0, bb} + (rs ? 17'd1 : {16'd0, rc});
        eovf = (ra[15] == bb[15]) && (full[15] != ra[15]);
        run_op(k, ra, rb, rc, rs, lat);
        checks++;
        if ({sum_v[k], cout_v[k], ovf_v[k]} !== {full[15:0], full[16], eovf}
            || lat != 16 / chunk_of(k)) begin
          errs++;
          $display("FAIL sweep_c%0d: a=%h b=%h cin=%b sub=%b got sum=%h cout=%b ovf=%b lat=%0d want %h %b %b %0d",
                   chunk_of(k), ra, rb, rc, rs, sum_v[k], cout_v[k], ovf_v[k], lat,
                   full[15:0], full[16], eovf, 16 / chunk_of(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_ovf_sub();
    test_back_to_back();
    test_abort();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
